// File: rtl/pe_lin_array.sv
// pe_lin_array: 1-D weight-stationary systolic MAC row. Activations ripple one PE per
// cycle with valid/last tags; each PE saturates its accumulator and publishes on last.
module pe_lin_cell #(
   parameter int DW = 8,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          w_we_i,
   input  logic [DW-1:0] w_i,
   input  logic          v_i,
   input  logic [DW-1:0] a_i,
   input  logic          last_i,
   output logic [AW-1:0] acc_o,
   output logic          valid_o,
   output logic          ovf_o
);
   // Sum is wide enough that neither the product nor the carry can wrap before the compare.
   localparam int SW = ((AW > 2*DW) ? AW : 2*DW) + 1;
   localparam logic [SW-1:0] MAXV = SW'({AW{1'b1}});

   logic [DW-1:0] w_q;
   logic [AW-1:0] acc_q, acc_d, res_q, res_d, acc_sat;
   logic          ovf_q, ovf_d, vo_q, vo_d, fo_q, fo_d, sat;
   logic [SW-1:0] sum;

   always_comb begin
      sum     = SW'(acc_q) + SW'(a_i) * SW'(w_q);
      sat     = sum > MAXV;
      acc_sat = sat ? {AW{1'b1}} : sum[AW-1:0];
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      res_d   = res_q;
      vo_d    = 1'b0;
      fo_d    = 1'b0;
      if (clr_i) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (v_i) begin
         if (last_i) begin
            res_d = acc_sat;
            fo_d  = ovf_q | sat;
            vo_d  = 1'b1;
            acc_d = '0;
            ovf_d = 1'b0;
         end else begin
            acc_d = acc_sat;
            ovf_d = ovf_q | sat;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q   <= '0;
         acc_q <= '0;
         ovf_q <= 1'b0;
         res_q <= '0;
         vo_q  <= 1'b0;
         fo_q  <= 1'b0;
      end else begin
         if (w_we_i) w_q <= w_i;
         acc_q <= acc_d;
         ovf_q <= ovf_d;
         res_q <= res_d;
         vo_q  <= vo_d;
         fo_q  <= fo_d;
      end
   end

   assign acc_o   = res_q;
   assign valid_o = vo_q;
   assign ovf_o   = fo_q;
endmodule

module pe_lin_array #(
   parameter int N_PE = 4,
   parameter int DW   = 8,
   parameter int AW   = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             w_load,
   input  logic [N_PE*DW-1:0] w_data,
   output logic             w_err,
   input  logic             in_valid,
   input  logic [DW-1:0]    in_a,
   input  logic             in_last,
   output logic [N_PE*AW-1:0] o_acc,
   output logic [N_PE-1:0]  o_valid,
   output logic [N_PE-1:0]  o_ovf,
   output logic             busy
);
   // Tag stage j feeds PE j+1; a single dummy stage exists when N_PE == 1.
   localparam int NT = (N_PE > 1) ? N_PE - 1 : 1;

   logic [NT-1:0]           v_q, l_q;
   logic [NT-1:0][DW-1:0]   a_q;
   logic [N_PE-1:0]         pv, pl;
   logic [N_PE-1:0][DW-1:0] pa;
   logic                    w_we, w_err_q;

   assign busy  = (N_PE > 1) ? |v_q : 1'b0;
   assign w_we  = w_load & ~busy & ~in_valid;
   assign w_err = w_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q     <= '0;
         a_q     <= '0;
         l_q     <= '0;
         w_err_q <= 1'b0;
      end else begin
         w_err_q <= w_load & ~w_we;
         if (clr) begin
            v_q <= '0;
         end else begin
            for (int j = NT - 1; j > 0; j--) begin
               v_q[j] <= v_q[j-1];
               a_q[j] <= a_q[j-1];
               l_q[j] <= l_q[j-1];
            end
            v_q[0] <= in_valid;
            a_q[0] <= in_a;
            l_q[0] <= in_last;
         end
      end
   end

   for (genvar i = 0; i < N_PE; i++) begin : g_pe
      if (i == 0) begin : g_head
         assign pv[i] = in_valid;
         assign pa[i] = in_a;
         assign pl[i] = in_last;
      end else begin : g_body
         assign pv[i] = v_q[i-1];
         assign pa[i] = a_q[i-1];
         assign pl[i] = l_q[i-1];
      end
      pe_lin_cell #(.DW(DW), .AW(AW)) u_pe (
         .clk     (clk),
         .rst     (rst),
         .clr_i   (clr),
         .w_we_i  (w_we),
         .w_i     (w_data[i*DW +: DW]),
         .v_i     (pv[i]),
         .a_i     (pa[i]),
         .last_i  (pl[i]),
         .acc_o   (o_acc[i*AW +: AW]),
         .valid_o (o_valid[i]),
         .ovf_o   (o_ovf[i])
      );
   end
endmodule

// File: tb/tb_pe_lin_array.sv
// Directed bench for pe_lin_array at default parameters (4 PEs, 8-bit data, 12-bit acc).
module tb_pe_lin_array;
   localparam int N = 4, DW = 8, AW = 12;

   logic             clk = 1'b0;
   logic             rst, clr, w_load, in_valid, in_last;
   logic [N*DW-1:0]  w_data;
   logic [DW-1:0]    in_a;
   logic             w_err, busy;
   logic [N*AW-1:0]  o_acc;
   logic [N-1:0]     o_valid, o_ovf;
   int               n_chk = 0, n_fail = 0;

   pe_lin_array #(.N_PE(N), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .clr(clr), .w_load(w_load), .w_data(w_data), .w_err(w_err),
      .in_valid(in_valid), .in_a(in_a), .in_last(in_last), .o_acc(o_acc),
      .o_valid(o_valid), .o_ovf(o_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic v, input logic [DW-1:0] a, input logic l);
      in_valid = v; in_a = a; in_last = l;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = '0; in_last = 1'b0;
   endtask

   task automatic load_w(input logic [N*DW-1:0] w);
      w_load = 1'b1; w_data = w;
      @(posedge clk); #1;
      w_load = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; clr = 1'b0; w_load = 1'b0; w_data = '0;
      in_valid = 1'b0; in_a = '0; in_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (o_acc !== '0 || o_valid !== '0 || o_ovf !== '0 || w_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: acc=%h v=%b ovf=%b werr=%b busy=%b, want all zero",
                  o_acc, o_valid, o_ovf, w_err, busy);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [AW-1:0] exp_b [N] = '{12'd18, 12'd36, 12'd54, 12'd72};
      load_w({8'd4, 8'd3, 8'd2, 8'd1});
      n_chk++;
      if (w_err !== 1'b0) begin
         n_fail++; $display("FAIL basic_werr: got %b want 0", w_err);
      end
      cyc(1, 8'd5, 0);
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL basic_busy: got %b want 1", busy);
      end
      cyc(1, 8'd6, 0);
      cyc(1, 8'd7, 1);
      for (int k = 0; k < N; k++) begin
         if (k > 0) cyc(0, '0, 0);
         n_chk++;
         if (o_valid !== N'(1 << k) || o_acc[k*AW +: AW] !== exp_b[k] || o_ovf !== '0) begin
            n_fail++;
            $display("FAIL basic_pe%0d: v=%b acc=%0d ovf=%b, want v=%b acc=%0d ovf=0",
                     k, o_valid, o_acc[k*AW +: AW], o_ovf, N'(1 << k), exp_b[k]);
         end
      end
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_idle_busy: got %b want 0", busy);
      end
      cyc(0, '0, 0);
      n_chk++;
      if (o_valid !== '0 || o_acc !== {12'd72, 12'd54, 12'd36, 12'd18}) begin
         n_fail++; $display("FAIL basic_hold: v=%b acc=%h want v=0 acc=048036024012", o_valid, o_acc);
      end
   endtask

   task automatic test_last_noval;
      cyc(0, 8'd9, 1);
      for (int k = 0; k < N; k++) begin
         n_chk++;
         if (o_valid !== '0) begin
            n_fail++; $display("FAIL last_noval_%0d: v=%b want 0", k, o_valid);
         end
         cyc(0, '0, 0);
      end
   endtask

   task automatic test_saturate;
      load_w({N{8'd255}});
      cyc(1, 8'd255, 1);
      for (int k = 0; k < N; k++) begin
         if (k > 0) cyc(0, '0, 0);
         n_chk++;
         if (o_valid !== N'(1 << k) || o_acc[k*AW +: AW] !== 12'd4095 || o_ovf !== N'(1 << k)) begin
            n_fail++;
            $display("FAIL sat_pe%0d: v=%b acc=%0d ovf=%b, want acc=4095 ovf=v=%b",
                     k, o_valid, o_acc[k*AW +: AW], o_ovf, N'(1 << k));
         end
      end
      cyc(1, 8'd1, 1);
      for (int k = 0; k < N; k++) begin
         if (k > 0) cyc(0, '0, 0);
         n_chk++;
         if (o_valid !== N'(1 << k) || o_acc[k*AW +: AW] !== 12'd255 || o_ovf !== '0) begin
            n_fail++;
            $display("FAIL sat_clear_pe%0d: v=%b acc=%0d ovf=%b, want acc=255 ovf=0",
                     k, o_valid, o_acc[k*AW +: AW], o_ovf);
         end
      end
      cyc(0, '0, 0);
   endtask

   task automatic test_back_to_back;
      logic [N-1:0]  ev;
      logic          bad;
      load_w({N{8'd10}});
      for (int k = 0; k <= N; k++) begin
         if (k == 0)      cyc(1, 8'd2, 1);
         else if (k == 1) cyc(1, 8'd3, 1);
         else             cyc(0, '0, 0);
         ev = '0; bad = 1'b0;
         for (int i = 0; i < N; i++) begin
            ev[i] = (k == i) || (k == i + 1);
            if (k == i && o_acc[i*AW +: AW] !== 12'd20) bad = 1'b1;
            if (k == i + 1 && o_acc[i*AW +: AW] !== 12'd30) bad = 1'b1;
         end
         n_chk++;
         if (o_valid !== ev || bad) begin
            n_fail++; $display("FAIL b2b_step%0d: v=%b acc=%h want v=%b (20 then 30)", k, o_valid, o_acc, ev);
         end
      end
      cyc(0, '0, 0);
   endtask

   task automatic test_wload_busy;
      cyc(1, 8'd1, 1);
      w_load = 1'b1; w_data = {N{8'd1}};
      @(posedge clk); #1;
      w_load = 1'b0;
      n_chk++;
      if (w_err !== 1'b1) begin
         n_fail++; $display("FAIL wload_busy_err: got %b want 1", w_err);
      end
      cyc(0, '0, 0);
      n_chk++;
      if (w_err !== 1'b0) begin
         n_fail++; $display("FAIL wload_err_pulse: got %b want 0", w_err);
      end
      repeat (3) cyc(0, '0, 0);
      cyc(1, 8'd2, 1);
      repeat (N - 1) cyc(0, '0, 0);
      n_chk++;
      if (o_acc !== {N{12'd20}}) begin
         n_fail++; $display("FAIL wload_weights_kept: acc=%h want all 20 (014)", o_acc);
      end
      cyc(0, '0, 0);
   endtask

   task automatic test_clr;
      logic seen;
      cyc(1, 8'd1, 0);
      cyc(1, 8'd2, 0);
      clr = 1'b1;
      cyc(1, 8'd3, 1);
      clr = 1'b0;
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL clr_busy: got %b want 0", busy);
      end
      seen = 1'b0;
      for (int k = 0; k < N + 1; k++) begin
         if (o_valid !== '0) seen = 1'b1;
         cyc(0, '0, 0);
      end
      n_chk++;
      if (seen || o_acc !== {N{12'd20}}) begin
         n_fail++; $display("FAIL clr_quiet: pulse_seen=%b acc=%h want 0 / all 014", seen, o_acc);
      end
      cyc(1, 8'd4, 1);
      n_chk++;
      if (o_valid !== 4'b0001 || o_acc[AW-1:0] !== 12'd40) begin
         n_fail++; $display("FAIL clr_fresh: v=%b acc0=%0d want v=0001 acc0=40", o_valid, o_acc[AW-1:0]);
      end
   endtask

   task automatic test_async_rst;
      cyc(1, 8'd5, 0);
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (o_acc !== '0 || o_valid !== '0 || o_ovf !== '0 || busy !== 1'b0 || w_err !== 1'b0) begin
         n_fail++; $display("FAIL async_rst: acc=%h v=%b ovf=%b busy=%b werr=%b want all zero",
                            o_acc, o_valid, o_ovf, busy, w_err);
      end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      cyc(1, 8'd5, 1);
      n_chk++;
      if (o_valid !== 4'b0001 || o_acc[AW-1:0] !== 12'd0) begin
         n_fail++; $display("FAIL rst_weights: v=%b acc0=%0d want v=0001 acc0=0", o_valid, o_acc[AW-1:0]);
      end
      repeat (N) cyc(0, '0, 0);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_last_noval;
      test_saturate;
      test_back_to_back;
      test_wload_busy;
      test_clr;
      test_async_rst;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
